// File: rtl/alu_r_arbiter.sv
// Round-robin arbiter sharing one R-type ALU between two requesters.
// One op in flight: IDLE (grant) -> EXEC (ALU evaluates latched operands) -> RESP (hold result).
module alu_r_arbiter #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned RR_INIT = 0
) (
    input  logic            iCLK,
    input  logic            iRST,
    input  logic            iREQ0_VALID,
    output logic            oREQ0_READY,
    input  logic [31:0]     iREQ0_IR,
    input  logic [XLEN-1:0] iREQ0_A,
    input  logic [XLEN-1:0] iREQ0_B,
    input  logic            iREQ1_VALID,
    output logic            oREQ1_READY,
    input  logic [31:0]     iREQ1_IR,
    input  logic [XLEN-1:0] iREQ1_A,
    input  logic [XLEN-1:0] iREQ1_B,
    output logic [31:0]     oALU_IR,
    output logic [XLEN-1:0] oALU_IN1,
    output logic [XLEN-1:0] oALU_IN2,
    input  logic [XLEN-1:0] iALU_OUT,
    output logic            oRSP_VALID,
    input  logic            iRSP_READY,
    output logic            oRSP_ID,
    output logic [4:0]      oRSP_RD,
    output logic [XLEN-1:0] oRSP_DATA
);

    localparam logic LP_PRIO_INIT = (RR_INIT != 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_RESP
    } state_t;

    state_t          r_state;
    logic            r_prio;
    logic [31:0]     r_ir;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic            r_id;
    logic            r_rsp_id;
    logic [4:0]      r_rsp_rd;
    logic [XLEN-1:0] r_rsp_data;

    logic w_idle;
    logic w_sel;
    logic w_rdy0;
    logic w_rdy1;

    // Reset gates READY so no grant is offered during the reset cycle.
    assign w_idle = (r_state == S_IDLE) && !iRST;
    assign w_sel  = (iREQ0_VALID && iREQ1_VALID) ? r_prio : iREQ1_VALID;
    assign w_rdy0 = w_idle && iREQ0_VALID && !w_sel;
    assign w_rdy1 = w_idle && iREQ1_VALID && w_sel;

    assign oREQ0_READY = w_rdy0;
    assign oREQ1_READY = w_rdy1;
    assign oALU_IR     = r_ir;
    assign oALU_IN1    = r_a;
    assign oALU_IN2    = r_b;
    assign oRSP_VALID  = (r_state == S_RESP);
    assign oRSP_ID     = r_rsp_id;
    assign oRSP_RD     = r_rsp_rd;
    assign oRSP_DATA   = r_rsp_data;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_state    <= S_IDLE;
            r_prio     <= LP_PRIO_INIT;
            r_ir       <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_id       <= 1'b0;
            r_rsp_id   <= 1'b0;
            r_rsp_rd   <= '0;
            r_rsp_data <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_rdy0 || w_rdy1) begin
                        r_ir    <= w_sel ? iREQ1_IR : iREQ0_IR;
                        r_a     <= w_sel ? iREQ1_A  : iREQ0_A;
                        r_b     <= w_sel ? iREQ1_B  : iREQ0_B;
                        r_id    <= w_sel;
                        r_prio  <= !w_sel;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    // Writes to x0 still retire, but with a zero result.
                    r_rsp_id   <= r_id;
                    r_rsp_rd   <= r_ir[11:7];
                    r_rsp_data <= (r_ir[11:7] == 5'd0) ? '0 : iALU_OUT;
                    r_state    <= S_RESP;
                end
                S_RESP: begin
                    if (iRSP_READY) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_r_arbiter.sv
// Scoreboard bench for alu_r_arbiter: per-requester drivers, a behavioural R-type ALU,
// and a monitor checking responses, handshake latency and READY suppression while busy.
module tb_alu_r_arbiter;

    typedef struct {
        logic [31:0] ir;
        logic [31:0] a;
        logic [31:0] b;
    } op_t;

    typedef struct {
        logic        id;
        logic [4:0]  rd;
        logic [31:0] data;
    } rsp_t;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b1;
    logic        iREQ0_VALID = 1'b0;
    logic        oREQ0_READY;
    logic [31:0] iREQ0_IR = '0;
    logic [31:0] iREQ0_A = '0;
    logic [31:0] iREQ0_B = '0;
    logic        iREQ1_VALID = 1'b0;
    logic        oREQ1_READY;
    logic [31:0] iREQ1_IR = '0;
    logic [31:0] iREQ1_A = '0;
    logic [31:0] iREQ1_B = '0;
    logic [31:0] oALU_IR;
    logic [31:0] oALU_IN1;
    logic [31:0] oALU_IN2;
    logic [31:0] iALU_OUT;
    logic        oRSP_VALID;
    logic        iRSP_READY = 1'b1;
    logic        oRSP_ID;
    logic [4:0]  oRSP_RD;
    logic [31:0] oRSP_DATA;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;
    int unsigned cyc = 0;
    int unsigned t_hs = 0;
    logic        busy = 1'b0;

    op_t  q0[$];
    op_t  q1[$];
    rsp_t exp_q[$];

    alu_r_arbiter #(.XLEN(32), .RR_INIT(0)) dut (
        .iCLK(iCLK), .iRST(iRST),
        .iREQ0_VALID(iREQ0_VALID), .oREQ0_READY(oREQ0_READY),
        .iREQ0_IR(iREQ0_IR), .iREQ0_A(iREQ0_A), .iREQ0_B(iREQ0_B),
        .iREQ1_VALID(iREQ1_VALID), .oREQ1_READY(oREQ1_READY),
        .iREQ1_IR(iREQ1_IR), .iREQ1_A(iREQ1_A), .iREQ1_B(iREQ1_B),
        .oALU_IR(oALU_IR), .oALU_IN1(oALU_IN1), .oALU_IN2(oALU_IN2),
        .iALU_OUT(iALU_OUT),
        .oRSP_VALID(oRSP_VALID), .iRSP_READY(iRSP_READY),
        .oRSP_ID(oRSP_ID), .oRSP_RD(oRSP_RD), .oRSP_DATA(oRSP_DATA)
    );

    always #5 iCLK = ~iCLK;
    always @(posedge iCLK) cyc <= cyc + 1;

    // Stand-in for the shared ALU; unsupported encodings yield 0.
    always_comb begin
        iALU_OUT = '0;
        case ({oALU_IR[31:25], oALU_IR[14:12]})
            {7'h00, 3'd0}: iALU_OUT = oALU_IN1 + oALU_IN2;
            {7'h20, 3'd0}: iALU_OUT = oALU_IN1 - oALU_IN2;
            {7'h00, 3'd1}: iALU_OUT = oALU_IN1 << oALU_IN2[4:0];
            {7'h00, 3'd4}: iALU_OUT = oALU_IN1 ^ oALU_IN2;
            {7'h00, 3'd5}: iALU_OUT = oALU_IN1 >> oALU_IN2[4:0];
            {7'h00, 3'd6}: iALU_OUT = oALU_IN1 | oALU_IN2;
            {7'h00, 3'd7}: iALU_OUT = oALU_IN1 & oALU_IN2;
            default:       iALU_OUT = '0;
        endcase
    end

    function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd);
        return {f7, 5'd2, 5'd1, f3, rd, 7'h33};
    endfunction

    function automatic op_t op(input logic [31:0] ir, input logic [31:0] a, input logic [31:0] b);
        op_t o;
        o.ir = ir; o.a = a; o.b = b;
        return o;
    endfunction

    function automatic rsp_t rsp(input logic id, input logic [4:0] rd, input logic [31:0] data);
        rsp_t r;
        r.id = id; r.rd = rd; r.data = data;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Requester 0 driver: holds VALID until accepted, then presents the next queued op.
    initial begin
        logic hs;
        forever begin
            @(negedge iCLK);
            hs = iREQ0_VALID && oREQ0_READY;
            @(posedge iCLK);
            #1;
            if (hs) iREQ0_VALID = 1'b0;
            if (!iREQ0_VALID && q0.size() > 0) begin
                op_t o;
                o = q0.pop_front();
                iREQ0_IR = o.ir; iREQ0_A = o.a; iREQ0_B = o.b;
                iREQ0_VALID = 1'b1;
            end
        end
    end

    initial begin
        logic hs;
        forever begin
            @(negedge iCLK);
            hs = iREQ1_VALID && oREQ1_READY;
            @(posedge iCLK);
            #1;
            if (hs) iREQ1_VALID = 1'b0;
            if (!iREQ1_VALID && q1.size() > 0) begin
                op_t o;
                o = q1.pop_front();
                iREQ1_IR = o.ir; iREQ1_A = o.a; iREQ1_B = o.b;
                iREQ1_VALID = 1'b1;
            end
        end
    end

    // Monitor: response contents vs scoreboard front, latency, and no grants while busy.
    always @(negedge iCLK) begin
        if (iRST) begin
            busy <= 1'b0;
        end else begin
            if (busy && cyc >= t_hs) begin
                chk("ready_while_busy", {62'd0, oREQ0_READY, oREQ1_READY}, 64'd0);
                if (cyc == t_hs) chk("valid_early", {63'd0, oRSP_VALID}, 64'd0);
                if (cyc == t_hs + 1) chk("valid_latency", {63'd0, oRSP_VALID}, 64'd1);
            end
            if (oRSP_VALID) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", {63'd0, oRSP_VALID}, 64'd0);
                end else begin
                    chk("rsp", {26'd0, oRSP_ID, oRSP_RD, oRSP_DATA},
                        {26'd0, exp_q[0].id, exp_q[0].rd, exp_q[0].data});
                    if (iRSP_READY) void'(exp_q.pop_front());
                end
                if (iRSP_READY) busy <= 1'b0;
            end
            if ((iREQ0_VALID && oREQ0_READY) || (iREQ1_VALID && oREQ1_READY)) begin
                chk("ready_onehot", {62'd0, oREQ0_READY, oREQ1_READY} == 64'd3 ? 64'd1 : 64'd0, 64'd0);
                busy <= 1'b1;
                t_hs <= cyc + 1;
            end
        end
    end

    task automatic wait_done(input string name);
        int unsigned n;
        n = 0;
        while ((exp_q.size() != 0 || busy || iREQ0_VALID || iREQ1_VALID) && n < 300) begin
            @(posedge iCLK);
            n++;
        end
        chk({name, "_timeout"}, {63'd0, n >= 300}, 64'd0);
        @(posedge iCLK);
        #1;
    endtask

    task automatic wait_rsp_valid(input string name);
        int unsigned n;
        n = 0;
        while (!oRSP_VALID && n < 50) begin
            @(posedge iCLK);
            #1;
            n++;
        end
        chk({name, "_rspwait"}, {63'd0, n >= 50}, 64'd0);
    endtask

    task automatic check_zero(input string name);
        chk({name, "_rsp_valid"}, {63'd0, oRSP_VALID}, 64'd0);
        chk({name, "_rsp_fields"}, {26'd0, oRSP_ID, oRSP_RD, oRSP_DATA}, 64'd0);
        chk({name, "_alu_ir"}, {32'd0, oALU_IR}, 64'd0);
        chk({name, "_alu_in"}, {oALU_IN1, oALU_IN2}, 64'd0);
    endtask

    initial begin
        // Test 1 op is queued during reset so READY suppression under reset is exercised.
        exp_q.push_back(rsp(1'b0, 5'd3, 32'd12));
        q0.push_back(op(32'h002081B3, 32'd5, 32'd7));
        repeat (2) @(posedge iCLK);
        @(negedge iCLK);
        chk("rst_ready0", {62'd0, iREQ0_VALID, oREQ0_READY}, 64'd2);
        check_zero("rst");
        @(posedge iCLK);
        #1 iRST = 1'b0;
        wait_done("t1");

        // Test 2: fresh reset so priority is back at requester 0.
        iRST = 1'b1;
        @(posedge iCLK);
        #1 iRST = 1'b0;
        exp_q.push_back(rsp(1'b0, 5'd3, 32'd7));
        exp_q.push_back(rsp(1'b1, 5'd3, 32'd2));
        q0.push_back(op(32'h402081B3, 32'd10, 32'd3));
        q1.push_back(op(32'h002081B3, 32'd1, 32'd1));
        wait_done("t2");

        // Test 3: both continuously valid, grants alternate.
        q0.push_back(op(mk(7'h00, 3'd0, 5'd5), 32'd100, 32'd23));
        q0.push_back(op(mk(7'h00, 3'd7, 5'd6), 32'h0000F0F0, 32'h0000FF00));
        q0.push_back(op(mk(7'h20, 3'd0, 5'd7), 32'd1, 32'd2));
        q0.push_back(op(mk(7'h00, 3'd1, 5'd8), 32'd1, 32'd4));
        q1.push_back(op(mk(7'h00, 3'd6, 5'd9), 32'h0F, 32'hF0));
        q1.push_back(op(mk(7'h00, 3'd4, 5'd10), 32'hFFFF, 32'h00FF));
        q1.push_back(op(mk(7'h00, 3'd5, 5'd11), 32'h80000000, 32'd31));
        q1.push_back(op(mk(7'h00, 3'd0, 5'd12), 32'hFFFFFFFF, 32'd1));
        exp_q.push_back(rsp(1'b0, 5'd5, 32'd123));
        exp_q.push_back(rsp(1'b1, 5'd9, 32'hFF));
        exp_q.push_back(rsp(1'b0, 5'd6, 32'hF000));
        exp_q.push_back(rsp(1'b1, 5'd10, 32'hFF00));
        exp_q.push_back(rsp(1'b0, 5'd7, 32'hFFFFFFFF));
        exp_q.push_back(rsp(1'b1, 5'd11, 32'd1));
        exp_q.push_back(rsp(1'b0, 5'd8, 32'd16));
        exp_q.push_back(rsp(1'b1, 5'd12, 32'd0));
        wait_done("t3");

        // Test 4: backpressure for 5 cycles with requester 1 waiting.
        iRSP_READY = 1'b0;
        exp_q.push_back(rsp(1'b0, 5'd13, 32'hFFFF));
        exp_q.push_back(rsp(1'b1, 5'd14, 32'd5));
        q0.push_back(op(mk(7'h00, 3'd4, 5'd13), 32'hAAAA, 32'h5555));
        q1.push_back(op(mk(7'h00, 3'd0, 5'd14), 32'd2, 32'd3));
        wait_rsp_valid("t4");
        repeat (5) @(posedge iCLK);
        #1 iRSP_READY = 1'b1;
        wait_done("t4");

        // Test 5: rd==0 retire and an unsupported encoding.
        exp_q.push_back(rsp(1'b0, 5'd0, 32'd0));
        exp_q.push_back(rsp(1'b1, 5'd15, 32'd0));
        q0.push_back(op(32'h00208033, 32'd5, 32'd7));
        q1.push_back(op(mk(7'h7F, 3'd0, 5'd15), 32'd3, 32'd4));
        wait_done("t5");

        // Test 6: reset while holding a response; priority had moved to requester 1.
        iRSP_READY = 1'b0;
        exp_q.push_back(rsp(1'b0, 5'd3, 32'd3));
        q0.push_back(op(mk(7'h00, 3'd0, 5'd3), 32'd1, 32'd2));
        wait_rsp_valid("t6");
        @(posedge iCLK);
        #1 iRST = 1'b1;
        @(posedge iCLK);
        #1 iRST = 1'b0;
        exp_q.delete();
        @(negedge iCLK);
        check_zero("t6_rst");
        iRSP_READY = 1'b1;
        exp_q.push_back(rsp(1'b0, 5'd4, 32'd12));
        exp_q.push_back(rsp(1'b1, 5'd5, 32'd5));
        @(posedge iCLK);
        #1;
        q0.push_back(op(mk(7'h00, 3'd0, 5'd4), 32'd6, 32'd6));
        q1.push_back(op(mk(7'h20, 3'd0, 5'd5), 32'd9, 32'd4));
        wait_done("t6");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
